// File: rtl/audipus_pkg.sv
// Shared audio-path constants: default I2S frame geometry and channel indices.
package audipus_pkg;

  localparam int unsigned DEFAULT_BCLK_HALF    = 4;
  localparam int unsigned DEFAULT_SAMPLE_WIDTH = 24;
  localparam int unsigned DEFAULT_SLOT_WIDTH   = 32;

  localparam int unsigned LEFT  = 0;
  localparam int unsigned RIGHT = 1;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider; flags the clk cycle in which bclk falls.
module i2s_bclk_gen
  import audipus_pkg::*;
#(
  parameter int unsigned BCLK_HALF = DEFAULT_BCLK_HALF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic bclk,
  output logic fall_c
);

  localparam int unsigned CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BCLK_HALF - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;
  logic             tc_c;

  always_comb begin
    cnt_d  = cnt_q;
    bclk_d = bclk_q;
    tc_c   = (cnt_q == CNT_MAX);
    if (!enable) begin
      cnt_d  = '0;
      bclk_d = 1'b0;
    end else if (tc_c) begin
      cnt_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk   = bclk_q;
  // High in the cycle whose clk edge drives bclk 1->0.
  assign fall_c = enable && tc_c && bclk_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S serializer: holding register, frame shift register, bit counter and word select.
module i2s_transmitter
  import audipus_pkg::*;
#(
  parameter int unsigned BCLK_HALF    = DEFAULT_BCLK_HALF,
  parameter int unsigned SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter int unsigned SLOT_WIDTH   = DEFAULT_SLOT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] left_data,
  input  logic [SAMPLE_WIDTH-1:0] right_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    dac_bclk,
  output logic                    dac_lrclk,
  output logic                    dac_data,
  output logic                    frame_start,
  output logic                    underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int unsigned B_W        = $clog2(FRAME_BITS);

  logic                    fall_c;
  logic                    start_c;
  logic [SLOT_WIDTH-1:0]   slot_l_c, slot_r_c;

  logic [SAMPLE_WIDTH-1:0] hold_q [2];
  logic [SAMPLE_WIDTH-1:0] hold_d [2];
  logic                    hold_empty_q, hold_empty_d;
  logic                    run_q, run_d;
  logic [B_W-1:0]          b_q, b_d;
  logic [FRAME_BITS-1:0]   shift_q, shift_d;
  logic                    lrclk_q, lrclk_d;
  logic                    frame_start_q, frame_start_d;
  logic                    underrun_q, underrun_d;

  i2s_bclk_gen #(
    .BCLK_HALF (BCLK_HALF)
  ) u_bclk_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .bclk    (dac_bclk),
    .fall_c  (fall_c)
  );

  // A frame begins on the first falling edge after enable, or when b wraps.
  assign start_c = fall_c && (!run_q || (b_q == B_W'(FRAME_BITS - 1)));

  always_comb begin
    hold_d        = hold_q;
    hold_empty_d  = hold_empty_q;
    run_d         = run_q;
    b_d           = b_q;
    shift_d       = shift_q;
    lrclk_d       = lrclk_q;
    frame_start_d = 1'b0;
    underrun_d    = 1'b0;

    slot_l_c = '0;
    slot_r_c = '0;
    slot_l_c[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_q[LEFT];
    slot_r_c[SLOT_WIDTH-1 -: SAMPLE_WIDTH] = hold_q[RIGHT];

    if (!enable) begin
      hold_d[LEFT]  = '0;
      hold_d[RIGHT] = '0;
      hold_empty_d  = 1'b1;
      run_d         = 1'b0;
      b_d           = '0;
      shift_d       = '0;
      lrclk_d       = 1'b0;
    end else begin
      if (fall_c) begin
        if (start_c) begin
          run_d         = 1'b1;
          b_d           = '0;
          frame_start_d = 1'b1;
          if (hold_empty_q) begin
            shift_d    = '0;
            underrun_d = 1'b1;
          end else begin
            shift_d      = {slot_l_c, slot_r_c};
            hold_empty_d = 1'b1;
          end
        end else begin
          b_d     = b_q + B_W'(1);
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
        end
        // Word select leads the slot by one bclk.
        lrclk_d = (b_d >= B_W'(SLOT_WIDTH - 1)) && (b_d != B_W'(FRAME_BITS - 1));
      end
      // Acceptance only when empty, so it never collides with a transfer.
      if (sample_valid && hold_empty_q) begin
        hold_d[LEFT]  = left_data;
        hold_d[RIGHT] = right_data;
        hold_empty_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q[LEFT]  <= '0;
      hold_q[RIGHT] <= '0;
      hold_empty_q  <= 1'b1;
      run_q         <= 1'b0;
      b_q           <= '0;
      shift_q       <= '0;
      lrclk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      hold_q        <= hold_d;
      hold_empty_q  <= hold_empty_d;
      run_q         <= run_d;
      b_q           <= b_d;
      shift_q       <= shift_d;
      lrclk_q       <= lrclk_d;
      frame_start_q <= frame_start_d;
      underrun_q    <= underrun_d;
    end
  end

  assign sample_ready = hold_empty_q;
  assign dac_lrclk    = lrclk_q;
  assign dac_data     = shift_q[FRAME_BITS-1];
  assign frame_start  = frame_start_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter at default geometry (24-bit samples, 32-bit slots).
module tb_i2s_transmitter;

  localparam int unsigned BCLK_HALF    = 4;
  localparam int unsigned SAMPLE_WIDTH = 24;
  localparam int unsigned SLOT_WIDTH   = 32;
  localparam logic [63:0] LR_MASK      = 64'h0000_0001_FFFF_FFFE;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    enable;
  logic [SAMPLE_WIDTH-1:0] left_data;
  logic [SAMPLE_WIDTH-1:0] right_data;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    dac_bclk;
  logic                    dac_lrclk;
  logic                    dac_data;
  logic                    frame_start;
  logic                    underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int fs_total  = 0;
  int acc_total = 0;
  int ur_total  = 0;

  always #5 clk = ~clk;

  i2s_transmitter #(
    .BCLK_HALF    (BCLK_HALF),
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .SLOT_WIDTH   (SLOT_WIDTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .left_data    (left_data),
    .right_data   (right_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_bclk     (dac_bclk),
    .dac_lrclk    (dac_lrclk),
    .dac_data     (dac_data),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always @(posedge clk) begin
    if (frame_start) fs_total++;
    if (underrun) ur_total++;
    if (sample_valid && sample_ready) acc_total++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_bclk(input logic rising);
    logic prev;
    bit   hit;
    prev = dac_bclk;
    hit  = 1'b0;
    for (int k = 0; k < 4 * BCLK_HALF && !hit; k++) begin
      @(negedge clk);
      hit  = (dac_bclk == rising) && (prev != rising);
      prev = dac_bclk;
    end
    if (!hit) check("bclk_edge", 64'(hit), 64'd1);
  endtask

  task automatic wait_frame_start(output bit hit);
    hit = 1'b0;
    for (int k = 0; k < 1200 && !hit; k++) begin
      @(negedge clk);
      hit = frame_start;
    end
    if (!hit) check("frame_start_seen", 64'(hit), 64'd1);
  endtask

  task automatic push(input logic [SAMPLE_WIDTH-1:0] l, input logic [SAMPLE_WIDTH-1:0] r);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 1200 && !done; k++) begin
      @(negedge clk);
      if (sample_ready) begin
        left_data    = l;
        right_data   = r;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        done         = 1'b1;
      end
    end
    if (!done) check("push_accept", 64'(done), 64'd1);
  endtask

  // Records one frame as seen by a receiver sampling on bclk rising edges.
  task automatic capture_frame(output logic [63:0] data, output logic [63:0] lr,
                               output logic ur, output logic rdy_start, output logic rdy_mid);
    bit hit;
    data = '0;
    lr   = '0;
    rdy_mid = 1'b0;
    wait_frame_start(hit);
    ur        = underrun;
    rdy_start = sample_ready;
    for (int i = 0; i < 64; i++) begin
      wait_bclk(1'b1);
      data[63-i] = dac_data;
      lr[63-i]   = dac_lrclk;
      if (i == 32) rdy_mid = sample_ready;
    end
  endtask

  initial begin
    logic [63:0] d, l;
    logic        ur, rs, rm;
    int          f0, a0, u0;
    bit          hit;

    reset_n = 1'b0; enable = 1'b0; sample_valid = 1'b0;
    left_data = '0; right_data = '0;
    repeat (2) @(negedge clk);
    check("rst_bclk",   64'(dac_bclk),     64'd0);
    check("rst_lrclk",  64'(dac_lrclk),    64'd0);
    check("rst_data",   64'(dac_data),     64'd0);
    check("rst_fs",     64'(frame_start),  64'd0);
    check("rst_ur",     64'(underrun),     64'd0);
    check("rst_ready",  64'(sample_ready), 64'd1);

    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;

    // Pair loaded before the first frame.
    push(24'hA5A5A5, 24'h5A5A5A);
    capture_frame(d, l, ur, rs, rm);
    check("f1_data",  d, 64'hA5A5A500_5A5A5A00);
    check("f1_lrclk", l, LR_MASK);
    check("f1_ur",    64'(ur), 64'd0);

    // Nothing supplied: silent frame with underrun.
    capture_frame(d, l, ur, rs, rm);
    check("f2_data",     d, 64'd0);
    check("f2_lrclk",    l, LR_MASK);
    check("f2_ur",       64'(ur), 64'd1);
    check("f2_rdy_start", 64'(rs), 64'd1);
    check("f2_rdy_mid",  64'(rm), 64'd1);

    // Valid presented in the frame-start clk itself.
    repeat (3) @(negedge clk);
    left_data = 24'h123456; right_data = 24'hFEDCBA; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    check("f3_fs",    64'(frame_start),  64'd1);
    check("f3_ur",    64'(underrun),     64'd1);
    check("f3_ready", 64'(sample_ready), 64'd0);
    repeat (10) @(negedge clk);
    check("f3_ready_mid", 64'(sample_ready), 64'd0);
    capture_frame(d, l, ur, rs, rm);
    check("f4_data",      d, 64'h12345600_FEDCBA00);
    check("f4_ur",        64'(ur), 64'd0);
    check("f4_rdy_start", 64'(rs), 64'd1);

    // Continuous valid: one accept per frame, no underruns.
    left_data = 24'h800001; right_data = 24'h7FFFFF; sample_valid = 1'b1;
    capture_frame(d, l, ur, rs, rm);
    check("f5_data",     d, 64'h80000100_7FFFFF00);
    check("f5_ur",       64'(ur), 64'd0);
    check("f5_rdy_start", 64'(rs), 64'd1);
    check("f5_rdy_mid",  64'(rm), 64'd0);
    f0 = fs_total; a0 = acc_total; u0 = ur_total;
    repeat (1536) @(negedge clk);
    check("cont_frames",  64'(fs_total - f0),  64'd3);
    check("cont_accepts", 64'(acc_total - a0), 64'd3);
    check("cont_underrun", 64'(ur_total - u0), 64'd0);
    sample_valid = 1'b0;

    // Drop enable at b=40 (right slot, bit 15 of 24'h7FFFFF).
    wait_frame_start(hit);
    push(24'h0F0F0F, 24'hF0F0F0);
    repeat (40) wait_bclk(1'b0);
    check("b40_lrclk", 64'(dac_lrclk),    64'd1);
    check("b40_data",  64'(dac_data),     64'd1);
    check("b40_ready", 64'(sample_ready), 64'd0);
    enable = 1'b0;
    @(negedge clk);
    check("dis_bclk",  64'(dac_bclk),     64'd0);
    check("dis_lrclk", 64'(dac_lrclk),    64'd0);
    check("dis_data",  64'(dac_data),     64'd0);
    check("dis_ready", 64'(sample_ready), 64'd1);
    repeat (5) @(negedge clk);
    check("dis_bclk_hold", 64'(dac_bclk), 64'd0);
    enable = 1'b1;
    push(24'hC00003, 24'h00000F);
    capture_frame(d, l, ur, rs, rm);
    check("reen_data",  d, 64'hC0000300_00000F00);
    check("reen_lrclk", l, LR_MASK);
    check("reen_ur",    64'(ur), 64'd0);

    // Asynchronous reset mid-frame.
    wait_frame_start(hit);
    check("pre_rst_ur", 64'(underrun), 64'd1);
    push(24'h111111, 24'h222222);
    repeat (300) @(negedge clk);
    check("pre_rst_lrclk", 64'(dac_lrclk),    64'd1);
    check("pre_rst_ready", 64'(sample_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    check("arst_bclk",  64'(dac_bclk),     64'd0);
    check("arst_lrclk", 64'(dac_lrclk),    64'd0);
    check("arst_data",  64'(dac_data),     64'd0);
    check("arst_fs",    64'(frame_start),  64'd0);
    check("arst_ur",    64'(underrun),     64'd0);
    check("arst_ready", 64'(sample_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("arst_hold_bclk", 64'(dac_bclk), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 64'(sample_ready), 64'd1);
    capture_frame(d, l, ur, rs, rm);
    check("post_rst_data",  d, 64'd0);
    check("post_rst_lrclk", l, LR_MASK);
    check("post_rst_ur",    64'(ur), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
